macroop_fetch: RTL and testbench

Byte-stream instruction fetcher for the 6502 core: on reset it reads the reset vector, then prefetches program bytes in order into a small buffer. It presents them one per cycle on the valid/ready macro-op port that the frontend's micro-op fetch consumes. A redirect input, from branch/jump resolution, flushes the buffer, squashes in-flight reads and restarts at a new PC.

---
 rtl/macroop_fetch_pkg.sv | 14 +
 rtl/macroop_fetch_if.sv | 34 +++
 rtl/fetch_fifo.sv | 46 ++++
 rtl/macroop_fetch.sv | 128 ++++++++++++
 tb/tb_macroop_fetch.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/macroop_fetch_pkg.sv
// macroop_fetch_pkg: shared constants and state encoding for the
// 6502 macro-op fetcher.
package macroop_fetch_pkg;

    localparam int          ADDR_W_DEF    = 16;
    localparam logic [15:0] RESET_VEC_DEF = 16'hFFFC;

    typedef enum logic [1:0] {
        VEC_LO = 2'd0,
        VEC_HI = 2'd1,
        STREAM = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/macroop_fetch_if.sv
// macroop_fetch_if: memory read port, macro-op output port and
// redirect input of the fetcher, bundled.
interface macroop_fetch_if
    import macroop_fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [7:0]        mem_rdata;
    logic [7:0]        instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [1:0]        fetch_state;

    modport master (
        output mem_req, mem_addr, instr, instr_pc, instr_valid,
        output fetch_state,
        input  mem_gnt, mem_rvalid, mem_rdata, instr_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, instr, instr_pc, instr_valid,
        input  fetch_state,
        output mem_gnt, mem_rvalid, mem_rdata, instr_ready,
        output redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO of {byte, addr} entries with
// push/pop/clear; pointers carry an extra wrap bit.
module fetch_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    input  logic [W-1:0]               wdata_i,
    output logic [W-1:0]               rdata_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wp_q, rp_q;

    assign count_o = wp_q - rp_q;
    assign rdata_o = mem_q[rp_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q <= '0;
            rp_q <= '0;
        end else if (clear_i) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (push_i) wp_q <= wp_q + 1'b1;
            if (pop_i)  rp_q <= rp_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wp_q[AW-1:0]] <= wdata_i;
    end

    // The credit rule upstream keeps a push off a full buffer.
    always_ff @(posedge clk) begin
        if (push_i && !pop_i && !clear_i)
            assert (count_o != (AW + 1)'(DEPTH));
    end
endmodule

// File: rtl/macroop_fetch.sv
// macroop_fetch: reads the reset vector, then prefetches bytes in
// order under a DEPTH credit limit; redirect flushes and squashes.
module macroop_fetch
    import macroop_fetch_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                DEPTH     = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF)
) (
    input logic             clk,
    input logic             rst,
    macroop_fetch_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int W  = ADDR_W + 8;

    fetch_state_e      st_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q, pc_q, pc_d, trk_q;
    logic [7:0]        lo_q, disc_q, disc_d;
    logic [CW-1:0]     out_q, out_d, cnt_q, cnt_d;
    logic [CW:0]       inflight_d;
    logic [W-1:0]      head;
    logic              gnt, rv, live, redir, pop, push;
    logic              vec_done, credit, valid;

    assign gnt      = req_q & bus.mem_gnt;
    assign rv       = bus.mem_rvalid;
    assign live     = rv && (disc_q == '0);
    assign redir    = bus.redirect_valid;
    assign valid    = (cnt_q != '0);
    assign pop      = valid & bus.instr_ready;
    assign push     = live && (st_q == STREAM) && !redir;
    assign vec_done = live && (st_q != STREAM) && !redir;

    fetch_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (redir),
        .wdata_i ({bus.mem_rdata, trk_q}),
        .rdata_o (head),
        .count_o (cnt_q)
    );

    always_comb begin
        disc_d = disc_q;
        out_d  = out_q + CW'(gnt) - CW'(live);
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        pc_d   = pc_q;
        if (redir) begin
            // Everything still pending, including a same-cycle grant,
            // becomes discard; a same-cycle response is already paid.
            disc_d = disc_q + 8'(out_q) + 8'(gnt) - 8'(rv);
            out_d  = '0;
            cnt_d  = '0;
            pc_d   = bus.redirect_pc;
        end else begin
            if (rv && !live) disc_d = disc_q - 8'd1;
            if (vec_done && st_q == VEC_HI)
                pc_d = ADDR_W'({bus.mem_rdata, lo_q});
            else if (gnt && st_q == STREAM)
                pc_d = pc_q + ADDR_W'(1);
        end
    end

    assign inflight_d = {1'b0, cnt_d} + {1'b0, out_d};
    assign credit     = int'(inflight_d) < DEPTH;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q   <= VEC_LO;
            req_q  <= 1'b0;
            addr_q <= '0;
            pc_q   <= '0;
            trk_q  <= '0;
            lo_q   <= '0;
            disc_q <= '0;
            out_q  <= '0;
        end else begin
            disc_q <= disc_d;
            out_q  <= out_d;
            pc_q   <= pc_d;
            if (redir) begin
                st_q   <= STREAM;
                trk_q  <= bus.redirect_pc;
                req_q  <= credit;
                addr_q <= pc_d;
            end else begin
                unique case (st_q)
                    VEC_LO: begin
                        addr_q <= RESET_VEC;
                        req_q  <= req_q ? !gnt : (out_q == '0);
                        if (vec_done) begin
                            lo_q <= bus.mem_rdata;
                            st_q <= VEC_HI;
                        end
                    end
                    VEC_HI: begin
                        if (vec_done) begin
                            st_q   <= STREAM;
                            trk_q  <= pc_d;
                            req_q  <= credit;
                            addr_q <= pc_d;
                        end else begin
                            addr_q <= RESET_VEC + ADDR_W'(1);
                            req_q  <= req_q ? !gnt : (out_q == '0);
                        end
                    end
                    STREAM: begin
                        req_q  <= credit;
                        addr_q <= pc_d;
                        if (push) trk_q <= trk_q + ADDR_W'(1);
                    end
                    default: st_q <= VEC_LO;
                endcase
            end
        end
    end

    assign bus.mem_req     = req_q;
    assign bus.mem_addr    = addr_q;
    assign bus.instr_valid = valid;
    assign bus.instr       = valid ? head[W-1:ADDR_W] : 8'h00;
    assign bus.instr_pc    = valid ? head[ADDR_W-1:0] : '0;
    assign bus.fetch_state = st_q;
endmodule

// File: tb/tb_macroop_fetch.sv
// tb_macroop_fetch: directed phases and random traffic, checked
// against an in-order byte-stream model of program memory.
module tb_macroop_fetch;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    macroop_fetch_if #(.ADDR_W(16)) bus ();

    macroop_fetch #(
        .ADDR_W    (16),
        .DEPTH     (4),
        .RESET_VEC (16'hFFFC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          due;
        logic [15:0] addr;
    } rsp_t;

    logic [7:0]  mem [65536];
    rsp_t        rq [$];
    logic [15:0] got_pc [$];
    logic [15:0] exp_pc;
    int          cyc, last_due, lat, gnt_pct, nreq;
    int          errs, nchk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gp(input int i);
        return (i < got_pc.size()) ? 32'(got_pc[i]) : 32'hDEAD0000;
    endfunction

    // One clock of memory model + frontend; model checks every pop.
    task automatic step(input bit rdy, input bit rd,
                        input logic [15:0] rpc);
        bit g;
        int due;
        g = (int'($urandom_range(99)) < gnt_pct);
        bus.mem_gnt        = g;
        bus.instr_ready    = rdy;
        bus.redirect_valid = rd;
        bus.redirect_pc    = rpc;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = mem[rq[0].addr];
            rq.delete(0);
        end else begin
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 8'($urandom);
        end
        if (bus.mem_req && g) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            rq.push_back('{due, bus.mem_addr});
            if (bus.fetch_state == 2'd2) nreq++;
        end
        if (bus.instr_valid && rdy) begin
            chk("instr_byte", 32'(bus.instr), 32'(mem[exp_pc]));
            chk("instr_pc", 32'(bus.instr_pc), 32'(exp_pc));
            got_pc.push_back(bus.instr_pc);
            exp_pc = exp_pc + 16'd1;
        end
        if (rd) exp_pc = rpc;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_state(input logic [1:0] s, input bit rdy,
                              input int budget);
        for (int i = 0; i < budget && bus.fetch_state != s; i++)
            step(rdy, 1'b0, 16'h0);
        chk("reach_state", 32'(bus.fetch_state), 32'(s));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_instr"}, 32'(bus.instr), 32'd0);
        chk({tag, "_instr_pc"}, 32'(bus.instr_pc), 32'd0);
        chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
        chk({tag, "_state"}, 32'(bus.fetch_state), 32'd0);
    endtask

    task automatic quiet_inputs();
        bus.mem_gnt        = 1'b0;
        bus.mem_rvalid     = 1'b0;
        bus.mem_rdata      = 8'h00;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0;
    endtask

    initial begin
        errs = 0; nchk = 0; cyc = 0; last_due = 0;
        lat = 1; gnt_pct = 100; nreq = 0;
        quiet_inputs();
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'hFFFC] = 8'h34;
        mem[16'hFFFD] = 8'h12;
        mem[16'h1234] = 8'hA9;
        mem[16'h1235] = 8'h01;
        mem[16'h1236] = 8'h8D;
        exp_pc = 16'h1234;

        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b1;

        // Vector fetch, then backpressure with the frontend stalled
        step(1'b0, 1'b0, 16'h0);
        chk("vec_lo_req", 32'(bus.mem_req), 32'd1);
        chk("vec_lo_addr", 32'(bus.mem_addr), 32'hFFFC);
        wait_state(2'd1, 1'b0, 20);
        wait_state(2'd2, 1'b0, 20);
        chk("first_stream_addr", 32'(bus.mem_addr), 32'h1234);
        nreq = 0;
        repeat (12) step(1'b0, 1'b0, 16'h0);
        chk("bp_reads", 32'(nreq), 32'd4);
        chk("bp_req_low", 32'(bus.mem_req), 32'd0);
        chk("bp_valid", 32'(bus.instr_valid), 32'd1);
        chk("bp_head", 32'(bus.instr), 32'hA9);
        chk("bp_head_pc", 32'(bus.instr_pc), 32'h1234);
        got_pc.delete();
        repeat (6) step(1'b1, 1'b0, 16'h0);
        chk("order0", gp(0), 32'h1234);
        chk("order1", gp(1), 32'h1235);
        chk("order2", gp(2), 32'h1236);

        // Redirect with several reads in flight on a slow memory
        lat = 3;
        repeat (20) step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 16'h2000);
        chk("rd_valid_low", 32'(bus.instr_valid), 32'd0);
        chk("rd_req", 32'(bus.mem_req), 32'd1);
        chk("rd_addr", 32'(bus.mem_addr), 32'h2000);
        chk("rd_state", 32'(bus.fetch_state), 32'd2);
        got_pc.delete();
        repeat (20) step(1'b1, 1'b0, 16'h0);
        chk("rd_first_pc", gp(0), 32'h2000);
        chk("rd_second_pc", gp(1), 32'h2001);

        // Address wrap
        lat = 1;
        step(1'b1, 1'b1, 16'hFFFE);
        got_pc.delete();
        repeat (10) step(1'b1, 1'b0, 16'h0);
        chk("wrap0", gp(0), 32'hFFFE);
        chk("wrap1", gp(1), 32'hFFFF);
        chk("wrap2", gp(2), 32'h0000);
        chk("wrap3", gp(3), 32'h0001);

        // Reset mid-stream: outputs drop without a clock edge
        rst = 1'b0;
        #1;
        check_idle("midreset");
        rq.delete();
        quiet_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_pc = 16'h1234;
        lat = 3;
        step(1'b0, 1'b0, 16'h0);
        chk("refetch_req", 32'(bus.mem_req), 32'd1);
        chk("refetch_addr", 32'(bus.mem_addr), 32'hFFFC);

        // Redirect while the high vector byte is pending
        wait_state(2'd1, 1'b0, 20);
        step(1'b0, 1'b0, 16'h0);
        chk("vh_req", 32'(bus.mem_req), 32'd1);
        chk("vh_addr", 32'(bus.mem_addr), 32'hFFFD);
        step(1'b0, 1'b0, 16'h0);
        chk("vh_pending", 32'(rq.size()), 32'd1);
        step(1'b1, 1'b1, 16'h3000);
        chk("vh_state", 32'(bus.fetch_state), 32'd2);
        chk("vh_req2", 32'(bus.mem_req), 32'd1);
        chk("vh_addr2", 32'(bus.mem_addr), 32'h3000);
        got_pc.delete();
        repeat (15) step(1'b1, 1'b0, 16'h0);
        chk("vh_first_pc", gp(0), 32'h3000);
        chk("vh_state_hold", 32'(bus.fetch_state), 32'd2);

        // Random grants, latencies, backpressure and redirects
        gnt_pct = 65;
        for (int n = 0; n < 3000; n++) begin
            lat = int'($urandom_range(4, 1));
            if ($urandom_range(99) < 2)
                step(($urandom_range(99) < 70), 1'b1, 16'($urandom));
            else
                step(($urandom_range(99) < 70), 1'b0, 16'h0);
        end

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
